// File: rtl/ripple_borrow_subtractor_seq_pkg.sv
// ripple_borrow_subtractor_seq_pkg: shared widths, FSM states and counter sizing for the subtractor
package ripple_borrow_subtractor_seq_pkg;
  localparam int SIZE_DEF = 32;
  localparam int CHUNK_DEF = 8;
  localparam int N_DEF = SIZE_DEF / CHUNK_DEF;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ripple_borrow_subtractor_seq_chunk_subtractor.sv
// chunk_subtractor: combinational CHUNK-bit ripple-borrow slice built from 1-bit full subtractors
module chunk_subtractor #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);
  logic [CHUNK:0] br;
  assign br[0] = bin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fs
    assign diff[i] = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign bout = br[CHUNK];
endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// ripple_borrow_subtractor_seq: multi-cycle a - b - bin, one CHUNK per cycle with valid/ready handshakes
module ripple_borrow_subtractor_seq
  import ripple_borrow_subtractor_seq_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            bout,
  output logic            ovf,
  output logic            zero
);
  localparam int N = SIZE / CHUNK;
  localparam int CW = cnt_width(N);
  state_t st;
  logic [N-1:0][CHUNK-1:0] a_r, b_r, dr, nd;
  logic [CW-1:0] cnt;
  logic [CHUNK-1:0] d;
  logic brw, bo, last;
  chunk_subtractor #(.CHUNK(CHUNK)) u_cs (
    .a   (a_r[cnt]),
    .b   (b_r[cnt]),
    .bin (brw),
    .diff(d),
    .bout(bo)
  );
  // result as it will look once the current slice is written back
  always_comb begin
    nd = dr;
    nd[cnt] = d;
  end
  assign last = cnt == CW'(N - 1);
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign diff = dr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      a_r <= '0;
      b_r <= '0;
      dr <= '0;
      cnt <= '0;
      brw <= 1'b0;
      bout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (st == IDLE) begin
      if (in_valid) begin
        st <= BUSY;
        a_r <= a;
        b_r <= b;
        dr <= '0;
        cnt <= '0;
        brw <= bin;
        bout <= 1'b0;
        ovf <= 1'b0;
        zero <= 1'b0;
      end
    end else if (st == BUSY) begin
      dr <= nd;
      brw <= bo;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        st <= DONE;
        bout <= bo;
        ovf <= (a_r[N-1][CHUNK-1] != b_r[N-1][CHUNK-1]) && (nd[N-1][CHUNK-1] != a_r[N-1][CHUNK-1]);
        zero <= nd == '0;
      end
    end else if (out_ready) begin
      st <= IDLE;
    end
  end
endmodule
